// File: rtl/stoch_im2col_pkg.sv
// Shared constants, state encoding and sizing helpers for the stochastic im2col blocks.
// Defaults describe a 12x12x256 image, 3x3 kernel, pad 2, stride 1 and 256-sample streams.
package stoch_im2col_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } state_t;

  function automatic int out_dim(input int im, input int pad, input int k, input int stride);
    return (im + 2 * pad - k) / stride + 1;
  endfunction

  // Counter width that never collapses to zero bits for single-entry ranges.
  function automatic int cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  localparam int DEF_IM_HEIGHT  = 12;
  localparam int DEF_IM_WIDTH   = 12;
  localparam int DEF_CHANNELS   = 256;
  localparam int DEF_KERNEL_H   = 3;
  localparam int DEF_KERNEL_W   = 3;
  localparam int DEF_PAD_H      = 2;
  localparam int DEF_PAD_W      = 2;
  localparam int DEF_STRIDE_H   = 1;
  localparam int DEF_STRIDE_W   = 1;
  localparam int DEF_STREAM_LEN = 256;

  localparam int DEF_OUT_H   = out_dim(DEF_IM_HEIGHT, DEF_PAD_H, DEF_KERNEL_H, DEF_STRIDE_H);
  localparam int DEF_OUT_W   = out_dim(DEF_IM_WIDTH, DEF_PAD_W, DEF_KERNEL_W, DEF_STRIDE_W);
  localparam int DEF_PATCH_W = DEF_KERNEL_H * DEF_KERNEL_W * DEF_CHANNELS;
  localparam int DEF_IM_BITS = DEF_IM_HEIGHT * DEF_IM_WIDTH * DEF_CHANNELS;
  localparam int DEF_POS_W   = cnt_w(DEF_OUT_H * DEF_OUT_W);
  localparam int DEF_SMP_W   = cnt_w(DEF_STREAM_LEN);

endpackage

// File: rtl/stoch_im2col_sched_if.sv
// Image-stream in / patch-stream out bundle for the im2col scheduler.
// The master side drives the image samples and output ready; the slave side is the scheduler.
interface stoch_im2col_sched_if
  import stoch_im2col_pkg::*;
#(
  parameter int IM_BITS = DEF_IM_BITS,
  parameter int PATCH_W = DEF_PATCH_W,
  parameter int POS_W   = DEF_POS_W
) ();

  logic               start;
  logic               in_valid;
  logic               in_ready;
  logic [IM_BITS-1:0] im_p;
  logic [IM_BITS-1:0] im_m;
  logic               out_valid;
  logic               out_ready;
  logic [PATCH_W-1:0] patch_p;
  logic [PATCH_W-1:0] patch_m;
  logic [POS_W-1:0]   pos_idx;
  logic               out_last;
  logic               busy;
  logic               done;

  modport master (
    output start, in_valid, im_p, im_m, out_ready,
    input  in_ready, out_valid, patch_p, patch_m, pos_idx, out_last, busy, done
  );

  modport slave (
    input  start, in_valid, im_p, im_m, out_ready,
    output in_ready, out_valid, patch_p, patch_m, pos_idx, out_last, busy, done
  );

endinterface

// File: rtl/stoch_im2col_patch_mux.sv
// Combinational patch gather: picks the KH x KW x CH window at output (row, col) from the
// plus/minus image samples; taps falling in the padding border read as 0. Zero latency.
module stoch_im2col_patch_mux
  import stoch_im2col_pkg::*;
#(
  parameter int IM_HEIGHT = DEF_IM_HEIGHT,
  parameter int IM_WIDTH  = DEF_IM_WIDTH,
  parameter int CHANNELS  = DEF_CHANNELS,
  parameter int KERNEL_H  = DEF_KERNEL_H,
  parameter int KERNEL_W  = DEF_KERNEL_W,
  parameter int PAD_H     = DEF_PAD_H,
  parameter int PAD_W     = DEF_PAD_W,
  parameter int STRIDE_H  = DEF_STRIDE_H,
  parameter int STRIDE_W  = DEF_STRIDE_W,
  parameter int ROW_W     = 4,
  parameter int COL_W     = 4
) (
  input  logic [IM_HEIGHT*IM_WIDTH*CHANNELS-1:0] im_p,
  input  logic [IM_HEIGHT*IM_WIDTH*CHANNELS-1:0] im_m,
  input  logic [ROW_W-1:0]                       row,
  input  logic [COL_W-1:0]                       col,
  output logic [KERNEL_H*KERNEL_W*CHANNELS-1:0]  patch_p,
  output logic [KERNEL_H*KERNEL_W*CHANNELS-1:0]  patch_m
);

  localparam int PLANE = IM_HEIGHT * IM_WIDTH;
  localparam int PIX_W = cnt_w(PLANE);

  for (genvar ch = 0; ch < CHANNELS; ch++) begin : g_ch
    for (genvar kr = 0; kr < KERNEL_H; kr++) begin : g_kr
      for (genvar kc = 0; kc < KERNEL_W; kc++) begin : g_kc
        localparam int BIT = kc + kr * KERNEL_W + ch * KERNEL_H * KERNEL_W;
        logic [PLANE-1:0] plane_p;
        logic [PLANE-1:0] plane_m;
        logic [PIX_W-1:0] pix;
        logic             hit;
        int               y;
        int               x;

        assign plane_p = im_p[ch*PLANE +: PLANE];
        assign plane_m = im_m[ch*PLANE +: PLANE];

        always_comb begin
          y   = int'(row) * STRIDE_H + kr - PAD_H;
          x   = int'(col) * STRIDE_W + kc - PAD_W;
          hit = (y >= 0) && (y < IM_HEIGHT) && (x >= 0) && (x < IM_WIDTH);
          pix = hit ? PIX_W'(y * IM_WIDTH + x) : '0;
        end

        assign patch_p[BIT] = hit & plane_p[pix];
        assign patch_m[BIT] = hit & plane_m[pix];
      end
    end
  end

endmodule

// File: rtl/stoch_im2col_sched.sv
// Walks output positions row-major, emitting STREAM_LEN registered patch samples per position.
// Latency 1 cycle from acceptance; in_ready drops while a held output is not taken.
module stoch_im2col_sched
  import stoch_im2col_pkg::*;
#(
  parameter int IM_HEIGHT  = 12,
  parameter int IM_WIDTH   = 12,
  parameter int CHANNELS   = 256,
  parameter int KERNEL_H   = 3,
  parameter int KERNEL_W   = 3,
  parameter int PAD_H      = 2,
  parameter int PAD_W      = 2,
  parameter int STRIDE_H   = 1,
  parameter int STRIDE_W   = 1,
  parameter int STREAM_LEN = 256
) (
  input logic                 clk,
  input logic                 rst,
  stoch_im2col_sched_if.slave bus
);

  localparam int OUT_H   = out_dim(IM_HEIGHT, PAD_H, KERNEL_H, STRIDE_H);
  localparam int OUT_W   = out_dim(IM_WIDTH, PAD_W, KERNEL_W, STRIDE_W);
  localparam int PATCH_W = KERNEL_H * KERNEL_W * CHANNELS;
  localparam int POS_W   = cnt_w(OUT_H * OUT_W);
  localparam int SMP_W   = cnt_w(STREAM_LEN);
  localparam int ROW_W   = cnt_w(OUT_H);
  localparam int COL_W   = cnt_w(OUT_W);

  state_t             state;
  state_t             state_nxt;
  logic [SMP_W-1:0]   smp;
  logic [ROW_W-1:0]   row;
  logic [COL_W-1:0]   col;
  logic [POS_W-1:0]   pos;
  logic [PATCH_W-1:0] mux_p;
  logic [PATCH_W-1:0] mux_m;
  logic [PATCH_W-1:0] patch_p_q;
  logic [PATCH_W-1:0] patch_m_q;
  logic [POS_W-1:0]   pos_q;
  logic               last_q;
  logic               valid_q;
  logic               done_q;
  logic               done_nxt;
  logic               clr;
  logic               in_ready;
  logic               accept;
  logic               smp_end;
  logic               col_end;
  logic               row_end;

  assign in_ready = (state == ST_RUN) && (!valid_q || bus.out_ready);
  assign accept   = bus.in_valid && in_ready;
  assign smp_end  = (smp == SMP_W'(STREAM_LEN - 1));
  assign col_end  = (col == COL_W'(OUT_W - 1));
  assign row_end  = (row == ROW_W'(OUT_H - 1));

  stoch_im2col_patch_mux #(
    .IM_HEIGHT(IM_HEIGHT), .IM_WIDTH(IM_WIDTH), .CHANNELS(CHANNELS),
    .KERNEL_H(KERNEL_H), .KERNEL_W(KERNEL_W), .PAD_H(PAD_H), .PAD_W(PAD_W),
    .STRIDE_H(STRIDE_H), .STRIDE_W(STRIDE_W), .ROW_W(ROW_W), .COL_W(COL_W)
  ) u_mux (
    .im_p(bus.im_p), .im_m(bus.im_m), .row(row), .col(col),
    .patch_p(mux_p), .patch_m(mux_m)
  );

  always_comb begin
    state_nxt = state;
    clr       = 1'b0;
    done_nxt  = 1'b0;
    case (state)
      ST_IDLE: begin
        if (bus.start) begin
          state_nxt = ST_RUN;
          clr       = 1'b1;
        end
      end
      ST_RUN: begin
        if (accept && smp_end && col_end && row_end) state_nxt = ST_DRAIN;
      end
      ST_DRAIN: begin
        // The last sample leaves the output register on this edge.
        if (!valid_q || bus.out_ready) begin
          state_nxt = ST_IDLE;
          done_nxt  = 1'b1;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= ST_IDLE;
      done_q <= 1'b0;
    end else begin
      state  <= state_nxt;
      done_q <= done_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      smp <= '0;
      row <= '0;
      col <= '0;
      pos <= '0;
    end else if (accept) begin
      if (smp_end) begin
        smp <= '0;
        if (col_end) begin
          col <= '0;
          row <= row_end ? '0 : row + ROW_W'(1);
          pos <= row_end ? '0 : pos + POS_W'(1);
        end else begin
          col <= col + COL_W'(1);
          pos <= pos + POS_W'(1);
        end
      end else begin
        smp <= smp + SMP_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q   <= 1'b0;
      patch_p_q <= '0;
      patch_m_q <= '0;
      pos_q     <= '0;
      last_q    <= 1'b0;
    end else if (accept) begin
      valid_q   <= 1'b1;
      patch_p_q <= mux_p;
      patch_m_q <= mux_m;
      pos_q     <= pos;
      last_q    <= smp_end;
    end else if (bus.out_ready) begin
      valid_q <= 1'b0;
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = valid_q;
  assign bus.patch_p   = patch_p_q;
  assign bus.patch_m   = patch_m_q;
  assign bus.pos_idx   = pos_q;
  assign bus.out_last  = last_q;
  assign bus.busy      = (state != ST_IDLE);
  assign bus.done      = done_q;

endmodule

// File: tb/tb_stoch_im2col_sched.sv
// Directed bench for the im2col scheduler on a 4x4x1 image, 3x3 kernel, pad 1, 4-sample streams.
module tb_stoch_im2col_sched;

  typedef struct {
    logic [3:0] pos;
    logic       last;
    logic [8:0] p;
    logic [8:0] m;
    int         tab;
  } exp_t;

  typedef struct {
    int          k;
    logic [15:0] ip;
    logic [15:0] im;
    logic [3:0]  pos;
    logic [8:0]  ep;
    logic [8:0]  em;
  } vec_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  stoch_im2col_sched_if #(.IM_BITS(16), .PATCH_W(9), .POS_W(4)) bus ();

  stoch_im2col_sched #(
    .IM_HEIGHT(4), .IM_WIDTH(4), .CHANNELS(1), .KERNEL_H(3), .KERNEL_W(3),
    .PAD_H(1), .PAD_W(1), .STRIDE_H(1), .STRIDE_W(1), .STREAM_LEN(4)
  ) dut (
    .clk(clk), .rst(rst), .bus(bus)
  );

  int          tests = 0;
  int          fails = 0;
  int          sent, got, done_cnt, tab_hits, cur_tab;
  bit          chk_hold, no_rdy;
  logic [31:0] hold_val;
  exp_t        q[$];
  vec_t        tab[9];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    tests++;
    if (act !== expv) begin
      fails++;
      $display("FAIL %s: actual=%0h expected=%0h at %0t", name, act, expv, $time);
    end
  endtask

  function automatic logic [8:0] model_patch(input logic [15:0] img, input int pos);
    logic [8:0]  p;
    logic [15:0] sh;
    int          r, c, y, x;
    p = '0;
    r = pos / 4;
    c = pos % 4;
    for (int kr = 0; kr < 3; kr++) begin
      for (int kc = 0; kc < 3; kc++) begin
        y = r + kr - 1;
        x = c + kc - 1;
        if (y >= 0 && y < 4 && x >= 0 && x < 4) begin
          sh = img >> (x + y * 4);
          p[kr*3+kc] = sh[0];
        end
      end
    end
    return p;
  endfunction

  function automatic logic [31:0] out_word();
    return 32'({bus.patch_p, bus.patch_m, bus.pos_idx, bus.out_last, bus.out_valid});
  endfunction

  // One clock: inspect handshakes just after the inputs settle, then advance to the next negedge.
  task automatic cycle();
    exp_t e;
    #1;
    if (bus.done) done_cnt++;
    if (no_rdy) check("bp_in_ready", 32'(bus.in_ready), 32'd0);
    if (chk_hold) check("hold_stable", out_word(), hold_val);
    chk_hold = bus.out_valid && !bus.out_ready;
    hold_val = out_word();
    if (bus.in_valid && bus.in_ready) begin
      e.pos  = 4'(sent / 4);
      e.last = (sent % 4 == 3);
      e.p    = model_patch(bus.im_p, sent / 4);
      e.m    = model_patch(bus.im_m, sent / 4);
      e.tab  = cur_tab;
      q.push_back(e);
      sent++;
    end
    if (bus.out_valid && bus.out_ready) begin
      if (q.size() == 0) begin
        check("spurious_out", 32'(q.size()), 32'd1);
      end else begin
        e = q.pop_front();
        check("out_word", 32'({bus.pos_idx, bus.out_last, bus.patch_p, bus.patch_m}),
              32'({e.pos, e.last, e.p, e.m}));
        if (e.tab >= 0) begin
          check("tab_pos", 32'(bus.pos_idx), 32'(tab[e.tab].pos));
          check("tab_patch_p", 32'(bus.patch_p), 32'(tab[e.tab].ep));
          check("tab_patch_m", 32'(bus.patch_m), 32'(tab[e.tab].em));
          tab_hits++;
        end
      end
      got++;
    end
    @(negedge clk);
  endtask

  task automatic check_cleared(input string tag);
    check({tag, "_busy"}, 32'(bus.busy), 32'd0);
    check({tag, "_out_valid"}, 32'(bus.out_valid), 32'd0);
    check({tag, "_in_ready"}, 32'(bus.in_ready), 32'd0);
    check({tag, "_pos_idx"}, 32'(bus.pos_idx), 32'd0);
    check({tag, "_patch_p"}, 32'(bus.patch_p), 32'd0);
    check({tag, "_patch_m"}, 32'(bus.patch_m), 32'd0);
    check({tag, "_out_last"}, 32'(bus.out_last), 32'd0);
    check({tag, "_done"}, 32'(bus.done), 32'd0);
  endtask

  task automatic run_frame(input bit gaps, input bit bp, input bit use_tab, input int rst_at);
    int cyc, bp_left;
    bit bp_done;
    sent = 0; got = 0; done_cnt = 0; tab_hits = 0; cur_tab = -1;
    q.delete();
    bus.out_ready = 1'b1;
    bus.in_valid  = 1'b0;
    bus.start     = 1'b1;
    cycle();
    bus.start = 1'b0;
    check("busy_after_start", 32'(bus.busy), 32'd1);
    cyc = 0; bp_left = 0; bp_done = 0;
    while (got < 64 && cyc < 1000) begin
      if (rst_at >= 0 && sent == rst_at) begin
        bus.in_valid = 1'b0;
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        check_cleared("midframe_rst");
        q.delete();
        chk_hold = 1'b0;
        return;
      end
      cur_tab = -1;
      if (use_tab) for (int i = 0; i < 9; i++) if (tab[i].k == sent) cur_tab = i;
      if (cur_tab >= 0) begin
        bus.im_p = tab[cur_tab].ip;
        bus.im_m = tab[cur_tab].im;
      end else if (gaps || bp) begin
        bus.im_p = 16'($urandom);
        bus.im_m = 16'($urandom);
      end else begin
        bus.im_p = 16'hFFFF;
        bus.im_m = 16'h0000;
      end
      bus.in_valid = (sent < 64) && (!gaps || (cyc % 2 == 0));
      if (bp && !bp_done && got == 10) begin
        bp_left = 3;
        bp_done = 1'b1;
      end
      bus.out_ready = (bp_left == 0);
      no_rdy        = (bp_left > 0);
      if (bp_left > 0) bp_left--;
      bus.start = use_tab && (sent >= 30) && (sent < 32);
      cycle();
      cyc++;
    end
    no_rdy = 1'b0;
    bus.in_valid = 1'b0;
    bus.start = 1'b0;
    bus.out_ready = 1'b1;
    cur_tab = -1;
    check("frame_outputs", 32'(got), 32'd64);
    check("frame_accepts", 32'(sent), 32'd64);
    cycle();
    check("done_after_last", 32'(done_cnt), 32'd1);
    check("idle_after_done", 32'(bus.busy), 32'd0);
    cycle();
    check("done_single_pulse", 32'(done_cnt), 32'd1);
    if (use_tab) check("tab_hits", 32'(tab_hits), 32'd9);
  endtask

  initial begin
    tab[0] = '{0,  16'hFFFF, 16'h0000, 4'd0,  9'h1B0, 9'h000};
    tab[1] = '{1,  16'h0000, 16'h0001, 4'd0,  9'h000, 9'h010};
    tab[2] = '{7,  16'h0000, 16'hFFFF, 4'd1,  9'h000, 9'h1F8};
    tab[3] = '{12, 16'hFFFF, 16'h0000, 4'd3,  9'h0D8, 9'h000};
    tab[4] = '{20, 16'hFFFF, 16'h0000, 4'd5,  9'h1FF, 9'h000};
    tab[5] = '{21, 16'h0020, 16'h0000, 4'd5,  9'h010, 9'h000};
    tab[6] = '{40, 16'h8000, 16'h0001, 4'd10, 9'h100, 9'h000};
    tab[7] = '{48, 16'hFFFF, 16'h0000, 4'd12, 9'h036, 9'h000};
    tab[8] = '{63, 16'hFFFF, 16'h0000, 4'd15, 9'h01B, 9'h000};

    rst = 1'b1;
    bus.start = 1'b0; bus.in_valid = 1'b0; bus.out_ready = 1'b0;
    bus.im_p = '0; bus.im_m = '0;
    chk_hold = 1'b0; no_rdy = 1'b0; cur_tab = -1;
    sent = 0; got = 0; done_cnt = 0; tab_hits = 0;
    @(negedge clk);
    cycle();
    cycle();
    check_cleared("reset");
    rst = 1'b0;

    // Image samples offered while idle must not be taken.
    bus.out_ready = 1'b1;
    bus.in_valid  = 1'b1;
    bus.im_p      = 16'hFFFF;
    for (int i = 0; i < 3; i++) begin
      cycle();
      check("idle_in_ready", 32'(bus.in_ready), 32'd0);
      check("idle_out_valid", 32'(bus.out_valid), 32'd0);
    end
    check("idle_no_accept", 32'(sent), 32'd0);
    bus.in_valid = 1'b0;

    run_frame(1'b0, 1'b0, 1'b1, -1);
    run_frame(1'b0, 1'b1, 1'b0, -1);
    run_frame(1'b1, 1'b0, 1'b0, -1);
    run_frame(1'b0, 1'b0, 1'b0, 20);
    run_frame(1'b0, 1'b0, 1'b0, -1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, tests=%0d", tests);
    $fatal(1);
  end

endmodule
